// File: rtl/led_matrix_scanner.sv
// rtl/led_matrix_scanner.sv - double-buffered 8x8 RGB frame store with row scan driver
module led_matrix_scanner #(
    parameter int SCAN_DIV     = 5000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       clear,
    input  logic       wr_en,
    input  logic [2:0] wr_row,
    input  logic [7:0] wr_r,
    input  logic [7:0] wr_g,
    input  logic [7:0] wr_b,
    output logic       wr_ready,
    input  logic       swap_req,
    output logic       swap_ack,
    output logic       frame_tick,
    output logic [7:0] DATA_R,
    output logic [7:0] DATA_G,
    output logic [7:0] DATA_B,
    output logic [2:0] COMM,
    output logic       EN
);

    localparam int CYC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(SCAN_DIV - 1);
    localparam logic [CYC_W-1:0] CYC_ONE   = CYC_W'(1);
    localparam logic [CYC_W-1:0] BLANK_END = CYC_W'(BLANK_CYCLES);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_COPY = 1'b1;

    // Scan position within the frame
    logic [CYC_W-1:0] cyc;
    logic [2:0]       row;

    // Bank selection and swap bookkeeping; fsel names the bank being displayed
    logic             fsel;
    logic             back_sel;
    logic             pend;

    // Post-swap copy sequencer
    logic [0:0]       state;
    logic [2:0]       copy_idx;

    // Two banks of eight rows, each row packed as {R, G, B}, active-low pixels
    logic [23:0]      bank [0:1][0:7];

    logic             row_end;
    logic             frame_end;
    logic             do_swap;
    logic             wr_accept;

    // Decode scan boundaries and the swap/write qualifiers for this cycle
    always_comb begin
        row_end   = (cyc == CYC_LAST);
        frame_end = row_end && (row == 3'd7);
        do_swap   = frame_end && (pend || swap_req);
        wr_accept = wr_en && wr_ready;
        back_sel  = ~fsel;
    end

    // Free-running row/column-time counters; the frame period never drifts
    always_ff @(posedge CLK) begin
        if (clear) begin
            cyc <= '0;
            row <= 3'd0;
        end else if (row_end) begin
            cyc <= '0;
            row <= row + 3'd1;
        end else begin
            cyc <= cyc + CYC_ONE;
        end
    end

    // Latch swap requests and flip the front bank only at a frame boundary
    always_ff @(posedge CLK) begin
        if (clear) begin
            fsel <= 1'b0;
            pend <= 1'b0;
        end else if (do_swap) begin
            fsel <= ~fsel;
            pend <= 1'b0;
        end else if (swap_req) begin
            pend <= 1'b1;
        end
    end

    // Copy sequencer: after a swap, refresh the new back bank from the new front bank
    always_ff @(posedge CLK) begin
        if (clear) begin
            state    <= ST_IDLE;
            copy_idx <= 3'd0;
            wr_ready <= 1'b1;
        end else if (do_swap) begin
            state    <= ST_COPY;
            copy_idx <= 3'd0;
            wr_ready <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wr_ready <= 1'b1;
                end
                ST_COPY: begin
                    copy_idx <= copy_idx + 3'd1;
                    if (copy_idx == 3'd7) begin
                        state    <= ST_IDLE;
                        wr_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    wr_ready <= 1'b1;
                end
            endcase
        end
    end

    // Bank storage: clear to dark, copy one row per cycle, or accept a game write
    // into the back bank (a write in the boundary cycle lands in the bank going front)
    always_ff @(posedge CLK) begin
        if (clear) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < 8; r++) begin
                    bank[b][r] <= 24'hFF_FFFF;
                end
            end
        end else if (state == ST_COPY) begin
            bank[back_sel][copy_idx] <= bank[fsel][copy_idx];
        end else if (wr_accept) begin
            bank[back_sel][wr_row] <= {wr_r, wr_g, wr_b};
        end
    end

    // Registered matrix drive: blank at the start of each row period, then front-bank pixels
    always_ff @(posedge CLK) begin
        if (clear) begin
            DATA_R     <= 8'hFF;
            DATA_G     <= 8'hFF;
            DATA_B     <= 8'hFF;
            COMM       <= 3'd0;
            EN         <= 1'b0;
            swap_ack   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            COMM       <= row;
            EN         <= 1'b1;
            frame_tick <= frame_end;
            swap_ack   <= do_swap;
            if (cyc < BLANK_END) begin
                DATA_R <= 8'hFF;
                DATA_G <= 8'hFF;
                DATA_B <= 8'hFF;
            end else begin
                {DATA_R, DATA_G, DATA_B} <= bank[fsel][row];
            end
        end
    end

endmodule
